// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like responder.
//   SIZE_BYTE/HALF/WORD : encodings carried on sram_size (informational only)
//   resp_entry_t        : one queued response {wr, rdata}
//   RESP_W              : bit width of resp_entry_t
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } resp_entry_t;

    localparam int RESP_W = $bits(resp_entry_t);

endpackage

// File: rtl/sram_resp_fifo.sv
// Synchronous FIFO that holds accepted-but-unanswered responses.
// The head entry is read straight from the storage registers.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i, wdata_i   enqueue (ignored when full)
//   pop_i, rdata_o    dequeue (ignored when empty); rdata_o is the head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
// Handshake: an entry is enqueued on an edge where push_i && !full_o, and
// dequeued on an edge where pop_i && !empty_o; both may happen on one edge.
module sram_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface, backed by a
// word RAM of 2**ADDR_W 32-bit entries. Requests are executed on the RAM at
// accept time; responses are returned in order after LATENCY cycles, with at
// most OUTSTANDING requests in flight.
// Optional feature macro: SRAM_RESP_RAND_STALL_EN adds an 8-bit LFSR that
// randomly deasserts sram_addr_ok (~25% of cycles).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   sram_req        request valid
//   sram_wr         1 = write, 0 = read
//   sram_size       access size (informational; wstrb governs writes)
//   sram_wstrb      write byte enables
//   sram_addr       byte address; word index = addr[ADDR_W+1:2]
//   sram_wdata      write data
//   sram_addr_ok    request accepted on an edge where sram_req && sram_addr_ok
//   sram_data_ok    one-cycle response strobe per accepted request
//   sram_rdata      read data with sram_data_ok, 0 otherwise
// Handshake: addr_ok is valid/ready style but does not depend on sram_req;
// data_ok has no back-pressure and is never held for more than one cycle.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         LATENCY     = 2,
    parameter int         OUTSTANDING = 4,
    parameter logic [7:0] STALL_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata
);

    localparam int              WAIT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(LATENCY - 1);
    localparam int              CNT_W       = $clog2(OUTSTANDING + 1);

    logic [31:0]       mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic              stall;
    logic              accept;
    logic              pop;
    resp_entry_t       push_entry;
    resp_entry_t       head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              unused_ok;

    assign word_idx = sram_addr[ADDR_W+1:2];

`ifdef SRAM_RESP_RAND_STALL_EN
    // Galois LFSR for x^8+x^6+x^5+x^4+1 (right-shifting, tap mask 0xB8).
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= STALL_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0] & lfsr_q[1];
`else
    assign stall = 1'b0;
`endif

    // Based only on registered occupancy, so a same-cycle pop never frees a slot.
    assign sram_addr_ok = !reset && !fifo_full && !stall;
    assign accept       = sram_req && sram_addr_ok;

    // Reads sample the RAM at accept time, giving program order against writes.
    assign push_entry.wr    = sram_wr;
    assign push_entry.rdata = sram_wr ? 32'h0 : mem_q[word_idx];

    always_ff @(posedge clk) begin
        if (accept && sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wstrb[i]) mem_q[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    sram_resp_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (RESP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // One timer serves the head entry only, so responses are spaced by LATENCY.
    assign sram_data_ok = !fifo_empty && (wait_q == '0);
    assign pop          = sram_data_ok;
    assign sram_rdata   = sram_data_ok ? head_entry.rdata : 32'h0;

    always_comb begin
        wait_d = wait_q;
        if (pop || (accept && fifo_empty)) begin
            wait_d = WAIT_RELOAD;
        end else if ((wait_q != '0) && !fifo_empty) begin
            wait_d = wait_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_q <= WAIT_RELOAD;
        else       wait_q <= wait_d;
    end

    // Address bits outside the word index and the size field are deliberately ignored.
    assign unused_ok = ^{sram_size, sram_addr[31:ADDR_W+2], sram_addr[1:0], fifo_count};

endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;
    localparam int OUTS  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic        req_a = 0, wr_a = 0, addr_ok_a, data_ok_a;
    logic [1:0]  size_a = 2'd2;
    logic [3:0]  wstrb_a = 0;
    logic [31:0] addr_a = 0, wdata_a = 0, rdata_a;
    logic        req_b = 0, wr_b = 0, addr_ok_b, data_ok_b;
    logic [1:0]  size_b = 2'd2;
    logic [3:0]  wstrb_b = 0;
    logic [31:0] addr_b = 0, wdata_b = 0, rdata_b;

    logic [32:0] exp_q_a[$];
    int          exp_t_a[$];
    logic [32:0] exp_q_b[$];
    int          exp_t_b[$];
    int          last_r_a = 0, last_r_b = 0;
    int          n_out_a = 0, n_out_b = 0;
    int          blk_a = 0, blk_b = 0;
    int          avail_a = 0, stall_a = 0;
    logic [31:0] model [16];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    sram_like_responder #(.ADDR_W(10), .LATENCY(LAT_A), .OUTSTANDING(OUTS), .STALL_SEED(8'hA5)) u_dut_a (
        .clk(clk), .reset(rst), .sram_req(req_a), .sram_wr(wr_a), .sram_size(size_a),
        .sram_wstrb(wstrb_a), .sram_addr(addr_a), .sram_wdata(wdata_a),
        .sram_addr_ok(addr_ok_a), .sram_data_ok(data_ok_a), .sram_rdata(rdata_a)
    );

    sram_like_responder #(.ADDR_W(10), .LATENCY(LAT_B), .OUTSTANDING(OUTS), .STALL_SEED(8'hA5)) u_dut_b (
        .clk(clk), .reset(rst), .sram_req(req_b), .sram_wr(wr_b), .sram_size(size_b),
        .sram_wstrb(wstrb_b), .sram_addr(addr_b), .sram_wdata(wdata_b),
        .sram_addr_ok(addr_ok_b), .sram_data_ok(data_ok_b), .sram_rdata(rdata_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    // Holds the request until accepted; on accept pushes {wr, rdata} and the
    // expected response edge max(accept, previous response) + LATENCY.
    task automatic issue(input int sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] exp_rd);
        int   tries;
        logic done;
        int   a;
        tries = 0;
        done  = 1'b0;
        @(negedge clk);
        if (sel == 0) begin
            req_a = 1; wr_a = wr; addr_a = addr; wdata_a = wdata; wstrb_a = wstrb;
        end else begin
            req_b = 1; wr_b = wr; addr_b = addr; wdata_b = wdata; wstrb_b = wstrb;
        end
        while (!done) begin
            if (((sel == 0) ? addr_ok_a : addr_ok_b) === 1'b1) begin
                done = 1'b1;
                a = cyc + 1;
                if (sel == 0) begin
                    last_r_a = ((a > last_r_a) ? a : last_r_a) + LAT_A;
                    exp_q_a.push_back({wr, wr ? 32'h0 : exp_rd});
                    exp_t_a.push_back(last_r_a);
                end else begin
                    last_r_b = ((a > last_r_b) ? a : last_r_b) + LAT_B;
                    exp_q_b.push_back({wr, wr ? 32'h0 : exp_rd});
                    exp_t_b.push_back(last_r_b);
                end
                @(posedge clk);
            end else if (tries > 60) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end else begin
                tries++;
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_a = 0;
        req_b = 0;
    endtask

    task automatic wait_drain();
        int k;
        idle();
        k = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", exp_q_a.size() + exp_q_b.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_a = 0;
        req_b = 0;
        rst   = 1;
        exp_q_a.delete(); exp_t_a.delete();
        exp_q_b.delete(); exp_t_b.delete();
        last_r_a = 0;
        last_r_b = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // ---------------- scoreboard monitors ----------------
    initial begin
        logic [32:0] e;
        int          t;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("rst_data_ok_a", 32'(data_ok_a), 32'd0);
                chk("rst_addr_ok_a", 32'(addr_ok_a), 32'd0);
                chk("rst_rdata_a", rdata_a, 32'h0);
                n_out_a = 0;
            end else begin
`ifdef SRAM_RESP_RAND_STALL_EN
                if (n_out_a >= OUTS) chk("full_addr_ok_a", 32'(addr_ok_a), 32'd0);
                else begin
                    avail_a++;
                    if (!addr_ok_a) stall_a++;
                end
`else
                chk("addr_ok_a", 32'(addr_ok_a), (n_out_a < OUTS) ? 32'd1 : 32'd0);
`endif
                if (req_a && !addr_ok_a) blk_a++;
                if (data_ok_a) begin
                    if (exp_q_a.size() == 0) chk("unexpected_resp_a", 32'd1, 32'd0);
                    else begin
                        e = exp_q_a.pop_front();
                        t = exp_t_a.pop_front();
                        chk(e[32] ? "wresp_rdata_a" : "rdata_a", rdata_a, e[31:0]);
                        chk("resp_edge_a", cyc + 1, t);
                    end
                end else if (rdata_a !== 32'h0) begin
                    chk("idle_rdata_a", rdata_a, 32'h0);
                end
                n_out_a = n_out_a + ((req_a && addr_ok_a) ? 1 : 0) - (data_ok_a ? 1 : 0);
            end
        end
    end

    initial begin
        logic [32:0] e;
        int          t;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("rst_data_ok_b", 32'(data_ok_b), 32'd0);
                n_out_b = 0;
            end else begin
`ifndef SRAM_RESP_RAND_STALL_EN
                chk("addr_ok_b", 32'(addr_ok_b), (n_out_b < OUTS) ? 32'd1 : 32'd0);
`endif
                if (req_b && !addr_ok_b) blk_b++;
                if (data_ok_b) begin
                    if (exp_q_b.size() == 0) chk("unexpected_resp_b", 32'd1, 32'd0);
                    else begin
                        e = exp_q_b.pop_front();
                        t = exp_t_b.pop_front();
                        chk("rdata_b", rdata_b, e[31:0]);
                        chk("resp_edge_b", cyc + 1, t);
                    end
                end else if (rdata_b !== 32'h0) begin
                    chk("idle_rdata_b", rdata_b, 32'h0);
                end
                n_out_b = n_out_b + ((req_b && addr_ok_b) ? 1 : 0) - (data_ok_b ? 1 : 0);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst = 0;

        // 1: word write then read back
        issue(0, 1, 32'h100, 32'h1234_5678, 4'hF, 0);
        issue(0, 0, 32'h100, 0, 4'h0, 32'h1234_5678);
        wait_drain();

        // 2: byte/half merges, aliasing and ignored low address bits
        issue(0, 1, 32'h104, 32'hFFFF_FFFF, 4'hF, 0);
        issue(0, 1, 32'h104, 32'h0000_00AB, 4'h1, 0);
        issue(0, 0, 32'h104, 0, 4'h0, 32'hFFFF_FFAB);
        issue(0, 1, 32'h104, 32'hBEEF_0000, 4'hC, 0);
        issue(0, 0, 32'h107, 0, 4'h0, 32'hBEEF_FFAB);
        issue(0, 0, 32'hF000_1104, 0, 4'h0, 32'hBEEF_FFAB);
        wait_drain();

        // 3: preload, then 8 reads with req held high; FIFO must fill
        for (int i = 0; i < 8; i++) issue(0, 1, 32'h200 + 4*i, 32'hC0DE_0000 + i, 4'hF, 0);
        wait_drain();
        blk_a = 0;
        for (int i = 0; i < 8; i++) issue(0, 0, 32'h200 + 4*i, 0, 4'h0, 32'hC0DE_0000 + i);
        wait_drain();
        chk("t3_addr_ok_dropped", (blk_a > 0) ? 32'd1 : 32'd0, 32'd1);

        // 4: LATENCY=1 instance, back-to-back reads answered every cycle
        for (int i = 0; i < 8; i++) issue(1, 1, 32'h40 + 4*i, 32'h5A5A_0000 + 16*i, 4'hF, 0);
        wait_drain();
        blk_b = 0;
        for (int i = 0; i < 8; i++) issue(1, 0, 32'h40 + 4*i, 0, 4'h0, 32'h5A5A_0000 + 16*i);
        wait_drain();
`ifndef SRAM_RESP_RAND_STALL_EN
        chk("t4_addr_ok_never_dropped", blk_b, 0);
`endif

        // 5: reset with 3 pending reads; RAM keeps its contents
        issue(0, 1, 32'h300, 32'hCAFE_F00D, 4'hF, 0);
        wait_drain();
        issue(0, 0, 32'h200, 0, 4'h0, 32'hC0DE_0000);
        issue(0, 0, 32'h204, 0, 4'h0, 32'hC0DE_0001);
        issue(0, 0, 32'h208, 0, 4'h0, 32'hC0DE_0002);
        do_reset();
        repeat (10) @(negedge clk);
        issue(0, 0, 32'h300, 0, 4'h0, 32'hCAFE_F00D);
        issue(0, 0, 32'h104, 0, 4'h0, 32'hBEEF_FFAB);
        wait_drain();

`ifdef SRAM_RESP_RAND_STALL_EN
        // 6: random reads/writes against a small model under random stalls
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            issue(0, 1, 32'h400 + 4*i, model[i], 4'hF, 0);
        end
        avail_a = 0;
        stall_a = 0;
        for (int n = 0; n < 1000; n++) begin
            int          idx;
            logic [31:0] d;
            logic [3:0]  s;
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(1, 15));
                for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                issue(0, 1, 32'h400 + 4*idx, d, s, 0);
            end else begin
                issue(0, 0, 32'h400 + 4*idx, 0, 4'h0, model[idx]);
            end
        end
        wait_drain();
        chk("t6_stall_duty_in_range",
            ((stall_a * 100 >= avail_a * 10) && (stall_a * 100 <= avail_a * 40)) ? 32'd1 : 32'd0, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
